// File: rtl/tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tag_fifo
//  Purpose  : Free-list of reorder/rename tags. It feeds the register status
//             table at dispatch. It is a circular FIFO that holds every tag
//             not currently in flight:
//               - dispatch pops a tag,
//               - commit pushes a retired tag back,
//               - flush restores the full tag set in one cycle.
//  Ports    : clk         - clock; all state changes on the rising edge
//             rst         - synchronous, active-high reset
//             alloc_req   - dispatch requests a tag this cycle
//             alloc_tag   - tag at the head of the list (valid when
//                           alloc_valid=1)
//             alloc_valid - list is non-empty; a pop happens only when
//                           alloc_req & alloc_valid
//             free_en     - commit returns free_tag this cycle
//             free_tag    - tag being returned
//             flush       - recovery: restore all tags; ovf_err is held
//             count       - number of free tags held (0..DEPTH)
//             full        - count == DEPTH
//             empty       - count == 0
//             ovf_err     - sticky; set when a push is attempted while full.
//                           Only rst clears it.
//  Revision : 1.0 - initial release
// ============================================================================
module tag_fifo #(
    parameter int TAG_W = 6,
    parameter int DEPTH = 64   // must equal 2**TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_valid,
    input  logic             free_en,
    input  logic [TAG_W-1:0] free_tag,
    input  logic             flush,
    output logic [TAG_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             ovf_err
);

    // The write pointer restarts at DEPTH, which sets the wrap bit.
    // With the read pointer at 0, the list therefore reads as full.
    localparam logic [TAG_W:0] c_PTR_FULL = (TAG_W + 1)'(DEPTH);
    localparam logic [TAG_W:0] c_PTR_ONE  = (TAG_W + 1)'(1);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [TAG_W:0]   r_rd_ptr;
    logic [TAG_W:0]   r_wr_ptr;
    logic             r_ovf_err;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf;

    assign w_empty = (r_rd_ptr == r_wr_ptr);
    assign w_full  = (r_rd_ptr[TAG_W-1:0] == r_wr_ptr[TAG_W-1:0]) &&
                     (r_rd_ptr[TAG_W] != r_wr_ptr[TAG_W]);

    // Both legality tests use the full/empty state from before the edge.
    // When the list is empty, free_tag is never bypassed to alloc_tag.
    // When the list is full, a simultaneous free counts as an overflow
    // even though a pop frees a slot at the same edge.
    assign w_pop  = alloc_req & ~w_empty;
    assign w_push = free_en & ~w_full;
    assign w_ovf  = free_en & w_full;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= TAG_W'(i);
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= c_PTR_FULL;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[TAG_W-1:0]] <= free_tag;
                r_wr_ptr                   <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Flush deliberately leaves the error flag untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (!flush && w_ovf) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign alloc_tag   = r_mem[r_rd_ptr[TAG_W-1:0]];
    assign alloc_valid = ~w_empty;
    assign count       = r_wr_ptr - r_rd_ptr;
    assign full        = w_full;
    assign empty       = w_empty;
    assign ovf_err     = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tag_fifo
//  Purpose  : Self-checking bench for tag_fifo.
//             The stimulus pushes every tag it expects to be allocated
//             into exp_q. A negedge monitor pops exp_q whenever the DUT
//             performs a pop, and compares alloc_tag with the popped value.
//             Status outputs are checked directly after each edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tag_fifo;

    localparam int TAG_W = 6;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_req;
    logic [TAG_W-1:0] alloc_tag;
    logic             alloc_valid;
    logic             free_en;
    logic [TAG_W-1:0] free_tag;
    logic             flush;
    logic [TAG_W:0]   count;
    logic             full;
    logic             empty;
    logic             ovf_err;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    tag_fifo #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_tag  (alloc_tag),
        .alloc_valid(alloc_valid),
        .free_en    (free_en),
        .free_tag   (free_tag),
        .flush      (flush),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. The monitor samples
    // at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 1'b0;
        free_en   = 1'b0;
        free_tag  = '0;
        flush     = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic pop_expect(input int tag);
        exp_q.push_back(tag);
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
    endtask

    task automatic push_tag(input int tag);
        free_en  = 1'b1;
        free_tag = TAG_W'(tag);
        step();
        free_en  = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && !flush && alloc_req && alloc_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got tag %0d expected no pop", alloc_tag);
            end else begin
                chk("pop_tag", 32'(alloc_tag), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 64);
        chk("rst_full", 32'(full), 1);
        chk("rst_empty", 32'(empty), 0);
        chk("rst_valid", 32'(alloc_valid), 1);
        chk("rst_tag", 32'(alloc_tag), 0);
        chk("rst_ovf", 32'(ovf_err), 0);

        // Drain: tags 0..63 come out in order
        alloc_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(i);
            step();
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);
        #1;
        chk("drain_65_valid", 32'(alloc_valid), 0);
        step();
        alloc_req = 1'b0;
        chk("drain_65_count", 32'(count), 0);
        chk("drain_65_empty", 32'(empty), 1);

        // Refill from empty, then pop in the same order
        push_tag(5);
        push_tag(9);
        push_tag(2);
        chk("refill_count", 32'(count), 3);
        pop_expect(5);
        pop_expect(9);
        pop_expect(2);
        chk("refill_empty", 32'(empty), 1);

        // Simultaneous pop and push with count=10
        for (int i = 10; i < 20; i++) push_tag(i);
        chk("simul_pre_count", 32'(count), 10);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(10 + i);
            alloc_req = 1'b1;
            free_en   = 1'b1;
            free_tag  = TAG_W'(7);
            step();
            chk("simul_count", 32'(count), 10);
        end
        idle();
        for (int i = 14; i < 20; i++) pop_expect(i);
        for (int i = 0; i < 4; i++) pop_expect(7);
        chk("simul_empty", 32'(empty), 1);

        // Empty list with both requests: the pop is refused and the push is
        // accepted
        alloc_req = 1'b1;
        free_en   = 1'b1;
        free_tag  = TAG_W'(33);
        step();
        idle();
        chk("eboth_valid", 32'(alloc_valid), 1);
        chk("eboth_tag", 32'(alloc_tag), 33);
        chk("eboth_count", 32'(count), 1);
        pop_expect(33);

        // Refill to full with a permutation. The write pointer crosses the
        // 2**(TAG_W+1) wrap point during this refill.
        for (int i = 0; i < DEPTH; i++) push_tag((i * 5 + 3) % DEPTH);
        chk("perm_full", 32'(full), 1);
        chk("perm_count", 32'(count), 64);

        // Free while full
        push_tag(4);
        chk("ovf_err", 32'(ovf_err), 1);
        chk("ovf_count", 32'(count), 64);
        chk("ovf_head", 32'(alloc_tag), 3);

        // Full with both requests: the pop proceeds and the push is dropped
        exp_q.push_back(3);
        alloc_req = 1'b1;
        free_en   = 1'b1;
        free_tag  = TAG_W'(4);
        step();
        idle();
        chk("fboth_count", 32'(count), 63);
        for (int i = 1; i < 21; i++) pop_expect((i * 5 + 3) % DEPTH);
        chk("pre_flush_count", 32'(count), 43);

        // Flush overrides the alloc and free requests in the same cycle
        alloc_req = 1'b1;
        free_en   = 1'b1;
        free_tag  = TAG_W'(50);
        flush     = 1'b1;
        step();
        idle();
        chk("flush_count", 32'(count), 64);
        chk("flush_tag", 32'(alloc_tag), 0);
        chk("flush_ovf_held", 32'(ovf_err), 1);
        chk("flush_full", 32'(full), 1);
        for (int i = 0; i < 5; i++) pop_expect(i);
        chk("post_flush_count", 32'(count), 59);

        // Reset clears the sticky error
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_ovf", 32'(ovf_err), 0);
        chk("rst2_count", 32'(count), 64);

        step();
        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
